// File: rtl/encoder_pkg.sv
// Shared constants and types for the registered 8-to-3 one-hot encoder.
package encoder_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = 3;

    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage : encoder_pkg

// File: rtl/encoder_8to3_core.sv
// Combinational priority encoder: highest set bit wins, with idle/multi-hot flags.
module encoder_8to3_core
    import encoder_pkg::*;
(
    input  logic [ENC_IN_W-1:0] vec,
    output enc_idx_t            idx,
    output logic                any,
    output logic                multi
);

    // Scan from the top bit down; the first hit sets the index, any later hit marks multi-hot.
    always_comb begin
        idx   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = ENC_IN_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                if (any) begin
                    multi = 1'b1;
                end else begin
                    idx = enc_idx_t'(i);
                end
                any = 1'b1;
            end
        end
    end

endmodule : encoder_8to3_core

// File: rtl/encoder_8to3_ot.sv
// Registered 8-to-3 one-hot encoder; outputs are flopped so no D-to-output path exists.
module encoder_8to3_ot
    import encoder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic D4,
    input  logic D5,
    input  logic D6,
    input  logic D7,
    output logic Y2,
    output logic Y1,
    output logic Y0,
    output logic V,
    output logic ERR
);

    logic [ENC_IN_W-1:0] vec;
    enc_idx_t            idx_c;
    logic                any_c;
    logic                multi_c;

    assign vec = {D7, D6, D5, D4, D3, D2, D1, D0};

    encoder_8to3_core u_core (
        .vec   (vec),
        .idx   (idx_c),
        .any   (any_c),
        .multi (multi_c)
    );

    // Output register with synchronous reset; reset discards any encoded value in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            {Y2, Y1, Y0} <= '0;
            V            <= 1'b0;
            ERR          <= 1'b0;
        end else begin
            {Y2, Y1, Y0} <= idx_c;
            V            <= any_c;
            ERR          <= multi_c;
        end
    end

endmodule : encoder_8to3_ot

// File: tb/tb_encoder_8to3_ot.sv
// Directed bench for encoder_8to3_ot; expected {Y2,Y1,Y0,V,ERR} values are hand-computed.
module tb_encoder_8to3_ot;

    logic clk = 1'b0;
    logic rst;
    logic D0, D1, D2, D3, D4, D5, D6, D7;
    logic Y2, Y1, Y0, V, ERR;

    int passed = 0;
    int total  = 0;

    encoder_8to3_ot dut (
        .clk (clk),
        .rst (rst),
        .D0  (D0),
        .D1  (D1),
        .D2  (D2),
        .D3  (D3),
        .D4  (D4),
        .D5  (D5),
        .D6  (D6),
        .D7  (D7),
        .Y2  (Y2),
        .Y1  (Y1),
        .Y0  (Y0),
        .V   (V),
        .ERR (ERR)
    );

    always #5 clk = ~clk;

    // Drive the request lines (bit n -> Dn), let one edge sample them, then settle past it.
    task automatic step(input logic [7:0] d);
        {D7, D6, D5, D4, D3, D2, D1, D0} = d;
        @(posedge clk);
        #1;
    endtask

    // Compare outputs against {Y[2:0], V, ERR}.
    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {Y2, Y1, Y0, V, ERR};
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed Y=%b V=%b ERR=%b, expected Y=%b V=%b ERR=%b",
                   tag, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        {D7, D6, D5, D4, D3, D2, D1, D0} = 8'h00;
        #2;

        // Reset held two cycles with D3 active
        step(8'b0000_1000); check("reset_cyc1", 5'b000_0_0);
        step(8'b0000_1000); check("reset_cyc2", 5'b000_0_0);
        rst = 1'b0;
        step(8'b0000_1000); check("post_reset_d3", 5'b011_1_0);

        // One-hot sweep
        step(8'b0000_0001); check("sweep_d0", 5'b000_1_0);
        step(8'b0000_0010); check("sweep_d1", 5'b001_1_0);
        step(8'b0000_0100); check("sweep_d2", 5'b010_1_0);
        step(8'b0000_1000); check("sweep_d3", 5'b011_1_0);
        step(8'b0001_0000); check("sweep_d4", 5'b100_1_0);
        step(8'b0010_0000); check("sweep_d5", 5'b101_1_0);
        step(8'b0100_0000); check("sweep_d6", 5'b110_1_0);
        step(8'b1000_0000); check("sweep_d7", 5'b111_1_0);

        // Idle versus D0
        step(8'b0000_0000); check("idle", 5'b000_0_0);
        step(8'b0000_0001); check("d0_vs_idle", 5'b000_1_0);

        // Multi-hot priority
        step(8'b0010_0100); check("multi_d2_d5", 5'b101_1_1);
        step(8'b1111_1111); check("multi_all", 5'b111_1_1);
        step(8'b0000_0011); check("multi_d0_d1", 5'b001_1_1);
        step(8'b1000_0001); check("multi_d0_d7", 5'b111_1_1);
        step(8'b0001_0000); check("multi_clears", 5'b100_1_0);

        // Mid-stream reset while the sweep is at D6
        step(8'b0010_0000); check("mid_d5", 5'b101_1_0);
        rst = 1'b1;
        step(8'b0100_0000); check("mid_reset", 5'b000_0_0);
        rst = 1'b0;
        step(8'b1000_0000); check("resume_d7", 5'b111_1_0);
        step(8'b0000_0001); check("resume_d0", 5'b000_1_0);
        step(8'b0000_0000); check("resume_idle", 5'b000_0_0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_encoder_8to3_ot
